result_tx_sequencer: RTL and testbench
======================================

RESULT_TX_SEQUENCER -- requirements
Module: result_tx_sequencer

Interface
REQ-001 Parameter: MSB_FIRST, default 0, meaning 0 sends byte 0 first (byte 0,1,2,3) and 1 sends byte 3 first (byte 3,2,1,0).
REQ-002 Parameter: GAP_CYCLES, default 2, meaning idle cycles between the end of one byte and the next tx_start (0 allowed).
REQ-003 Parameter: ACK_TIMEOUT, default 1023, meaning maximum cycles to wait for tx_busy to rise after tx_start (valid range 1..65535).
REQ-004 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: op_done  in  1  one-cycle pulse: a 32-bit result is valid at the byte handler input.
REQ-007 Port: tx_busy  in  1  UART transmitter busy flag.
REQ-008 Port: abort  in  1  synchronous cancel of the current frame.
REQ-009 Port: clear_err  in  1  clears the sticky error flags.
REQ-010 Port: register_result32  out  1  latch strobe to the byte handler.
REQ-011 Port: send_b0, send_b1, send_b2, send_b3  out  1 each  byte selects, at most one high.
REQ-012 Port: tx_start  out  1  one-cycle UART start pulse.
REQ-013 Port: seq_busy  out  1  high in every state except IDLE and ERROR.
REQ-014 Port: seq_done  out  1  one-cycle pulse when a 4-byte frame completes.
REQ-015 Port: err_timeout, err_overrun  out  1 each  sticky error flags.

Function
REQ-016 Outputs are decoded only from registered state (Moore): no combinational path from any input to any output.
REQ-017 The FSM has states IDLE, LATCH, SEND, WAIT_ACK, WAIT_DONE, GAP, DONE and ERROR.
REQ-018 IDLE: op_done=1 -> LATCH; byte index loads 0 (MSB_FIRST=0) or 3 (MSB_FIRST=1).
REQ-019 LATCH: register_result32=1 for exactly one cycle, then -> SEND.
REQ-020 Latency: with op_done high at edge N, register_result32 is high in cycle N+1 and tx_start in cycle N+2.
REQ-021 SEND: tx_start=1 and the current send_bX=1 for one cycle; clear the ack counter; -> WAIT_ACK.
REQ-022 The current send_bX stays high through SEND, WAIT_ACK and WAIT_DONE, and is low in every other state.
REQ-023 WAIT_ACK: tx_busy=1 -> WAIT_DONE; otherwise increment the ack counter.
REQ-024 WAIT_ACK timeout: when the ack counter reaches ACK_TIMEOUT with tx_busy still 0 -> ERROR, and err_timeout is set.
REQ-025 WAIT_DONE: tx_busy=0 with the last byte sent -> DONE; tx_busy=0 with bytes remaining -> GAP, and the index steps +1 or -1 per MSB_FIRST.
REQ-026 WAIT_DONE has no timeout.
REQ-027 GAP: count GAP_CYCLES cycles, then -> SEND; with GAP_CYCLES=0, WAIT_DONE goes directly to SEND.
REQ-028 DONE: seq_done=1 for one cycle, then -> IDLE.
REQ-029 ERROR: all strobes low and seq_busy=0; clear_err=1 -> IDLE and clears both error flags.
REQ-030 op_done while seq_busy=1 (LATCH through DONE) is ignored, sets err_overrun, and does not disturb the frame.
REQ-031 op_done in ERROR is ignored; it does not set err_overrun.
REQ-032 abort=1 in any state except IDLE and ERROR -> IDLE next cycle, with no seq_done and no error flag.
REQ-033 abort has priority over every other transition, including the timeout.
REQ-034 clear_err outside ERROR clears err_overrun only.
REQ-035 clear_err and op_done in the same IDLE cycle: both act.
REQ-036 The ack and gap counters are 16 bits wide and cleared on every state entry.
REQ-037 The byte index is 2 bits wide and never wraps within a frame.

Reset
REQ-038 reset=1 asynchronously forces state IDLE and clears the byte index, both counters and both error flags.
REQ-039 While reset=1, every output is 0.
REQ-040 Reset mid-frame drops the frame; the first op_done after reset release starts a fresh frame from LATCH.

Verification
REQ-041 Nominal, MSB_FIRST=0, GAP_CYCLES=2: op_done at cycle 0, tx_busy high 10 cycles after each tx_start -> register_result32 at cycle 1, tx_start at cycle 2, send order b0,b1,b2,b3, 2-cycle gaps, one seq_done.
REQ-042 MSB_FIRST=1, GAP_CYCLES=0: same stimulus -> send order b3,b2,b1,b0, next tx_start the cycle after tx_busy falls.
REQ-043 Timeout, ACK_TIMEOUT=8: tx_busy held 0 -> ERROR after 8 WAIT_ACK cycles, err_timeout=1, seq_busy=0; clear_err -> IDLE with flags 0.
REQ-044 Overrun: second op_done during the byte-1 WAIT_DONE -> err_overrun=1, frame completes all 4 bytes, exactly one seq_done.
REQ-045 Abort: abort during the byte-2 GAP -> IDLE next cycle, no further tx_start, no seq_done; a new op_done restarts at byte 0.
REQ-046 Reset: async reset asserted mid-WAIT_ACK between clock edges -> all outputs 0 immediately; after release, op_done gives register_result32 one cycle later.

Source files
------------

// File: rtl/result_tx_sequencer.sv
// Result byte sequencer: on op_done, latches a 32-bit result and walks its
// four bytes out through a UART transmitter, one tx_start per byte, with an
// ack timeout on tx_busy, an optional inter-byte gap and sticky error flags.
// All outputs decode from registered state only.
module result_tx_sequencer #(
  parameter int MSB_FIRST   = 0,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic op_done,
  input  logic tx_busy,
  input  logic abort,
  input  logic clear_err,
  output logic register_result32,
  output logic send_b0,
  output logic send_b1,
  output logic send_b2,
  output logic send_b3,
  output logic tx_start,
  output logic seq_busy,
  output logic seq_done,
  output logic err_timeout,
  output logic err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SEND, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0]  IDX_FIRST = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
  localparam logic [1:0]  IDX_LAST  = (MSB_FIRST != 0) ? 2'd0 : 2'd3;
  // Counters run from 0, so the last permitted count is limit-1.
  localparam logic [15:0] ACK_LIM   = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LIM   = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] ack_q, ack_d;
  logic [15:0] gap_q, gap_d;
  logic        eto_q, eto_d;
  logic        eov_q, eov_d;
  logic        in_frame;

  // State, byte index, counters and sticky flags; async reset drops everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ack_q   <= '0;
      gap_q   <= '0;
      eto_q   <= 1'b0;
      eov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      gap_q   <= gap_d;
      eto_q   <= eto_d;
      eov_q   <= eov_d;
    end
  end

  assign in_frame = (state_q != S_IDLE) && (state_q != S_ERROR);

  // Next-state logic: frame walk, timeout, overrun detection and abort override.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    gap_d   = gap_q;
    eto_d   = eto_q;
    eov_d   = eov_q;

    // clear_err outside ERROR only touches the overrun flag; a fresh overrun
    // in the same cycle wins because it is the newer event.
    if (clear_err && state_q != S_ERROR) eov_d = 1'b0;
    if (op_done && in_frame)             eov_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (op_done) begin
          state_d = S_LATCH;
          idx_d   = IDX_FIRST;
        end
      end
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        state_d = S_WAIT_ACK;
        ack_d   = '0;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_q == ACK_LIM) begin
          state_d = S_ERROR;
          eto_d   = 1'b1;
        end else begin
          ack_d = ack_q + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = (MSB_FIRST != 0) ? idx_q - 2'd1 : idx_q + 2'd1;
            state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LIM) state_d = S_SEND;
        else                  gap_d   = gap_q + 16'd1;
      end
      S_DONE: state_d = S_IDLE;
      S_ERROR: begin
        if (clear_err) begin
          state_d = S_IDLE;
          eto_d   = 1'b0;
          eov_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats every other transition, including a same-cycle timeout.
    if (abort && in_frame) begin
      state_d = S_IDLE;
      eto_d   = eto_q;
    end

    // Both counters restart on every state entry.
    if (state_d != state_q) begin
      ack_d = '0;
      gap_d = '0;
    end
  end

  // Moore output decode from registered state and byte index.
  always_comb begin
    logic sel_active;
    sel_active        = (state_q == S_SEND) || (state_q == S_WAIT_ACK) ||
                        (state_q == S_WAIT_DONE);
    register_result32 = (state_q == S_LATCH);
    tx_start          = (state_q == S_SEND);
    seq_done          = (state_q == S_DONE);
    seq_busy          = in_frame;
    send_b0           = sel_active && (idx_q == 2'd0);
    send_b1           = sel_active && (idx_q == 2'd1);
    send_b2           = sel_active && (idx_q == 2'd2);
    send_b3           = sel_active && (idx_q == 2'd3);
    err_timeout       = eto_q;
    err_overrun       = eov_q;
  end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer. Two instances share stimulus:
// u0 = LSB first, 2-cycle gap, ACK_TIMEOUT 8; u1 = MSB first, no gap,
// default timeout. A small UART model per instance raises tx_busy the cycle
// after tx_start and holds it for 10 sampled cycles.
module tb_result_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_done = 1'b0;
  logic       abort = 1'b0;
  logic       clear_err = 1'b0;
  logic [1:0] busy = '0;
  logic [1:0] uart_en = 2'b11;

  logic [1:0] regr, txs, sbusy, sdone, eto, eov;
  logic [7:0] selv;
  logic [9:0] outs0, outs1;

  int checks = 0;
  int errors = 0;

  int edge_n = 0;
  int e0 = 0;

  int ts_cnt [2];
  int ts_cyc [2][8];
  int ts_sel [2][8];
  int done_cnt [2];
  int done_cyc [2];
  int reg_cyc [2];
  int eto_cyc [2];
  int selh [2][64];

  int cd [2];
  int bl [2];

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  result_tx_sequencer #(.MSB_FIRST(0), .GAP_CYCLES(2), .ACK_TIMEOUT(8)) u0 (
    .clk(clk), .reset(reset), .op_done(op_done), .tx_busy(busy[0]),
    .abort(abort), .clear_err(clear_err),
    .register_result32(regr[0]),
    .send_b0(selv[0]), .send_b1(selv[1]), .send_b2(selv[2]), .send_b3(selv[3]),
    .tx_start(txs[0]), .seq_busy(sbusy[0]), .seq_done(sdone[0]),
    .err_timeout(eto[0]), .err_overrun(eov[0])
  );

  result_tx_sequencer #(.MSB_FIRST(1), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .op_done(op_done), .tx_busy(busy[1]),
    .abort(abort), .clear_err(clear_err),
    .register_result32(regr[1]),
    .send_b0(selv[4]), .send_b1(selv[5]), .send_b2(selv[6]), .send_b3(selv[7]),
    .tx_start(txs[1]), .seq_busy(sbusy[1]), .seq_done(sdone[1]),
    .err_timeout(eto[1]), .err_overrun(eov[1])
  );

  assign outs0 = {regr[0], selv[3:0], txs[0], sbusy[0], sdone[0], eto[0], eov[0]};
  assign outs1 = {regr[1], selv[7:4], txs[1], sbusy[1], sdone[1], eto[1], eov[1]};

  // UART model, driven on the falling edge so the DUT samples a stable level.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        busy[i] = 1'b0;
        cd[i]   = 0;
        bl[i]   = 0;
      end else if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) begin
          busy[i] = 1'b1;
          bl[i]   = 10;
        end
      end else if (busy[i]) begin
        bl[i] = bl[i] - 1;
        if (bl[i] == 0) busy[i] = 1'b0;
      end else if (txs[i] && uart_en[i]) begin
        cd[i] = 1;
      end
    end
  end

  // Event recorder; cycle k=1 is the cycle after op_done was sampled.
  always @(negedge clk) begin
    int k;
    k = edge_n - e0 + 1;
    for (int i = 0; i < 2; i++) begin
      if (txs[i] && ts_cnt[i] < 8) begin
        ts_cyc[i][ts_cnt[i]] = k;
        ts_sel[i][ts_cnt[i]] = int'(selv[i*4 +: 4]);
        ts_cnt[i] = ts_cnt[i] + 1;
      end
      if (sdone[i]) begin
        done_cnt[i] = done_cnt[i] + 1;
        done_cyc[i] = k;
      end
      if (regr[i] && reg_cyc[i] < 0) reg_cyc[i] = k;
      if (eto[i] && eto_cyc[i] < 0) eto_cyc[i] = k;
      if (k >= 0 && k < 64) selh[i][k] = int'(selv[i*4 +: 4]);
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_rec();
    for (int i = 0; i < 2; i++) begin
      ts_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
      reg_cyc[i] = -1; eto_cyc[i] = -1;
      for (int j = 0; j < 8; j++) begin ts_cyc[i][j] = -1; ts_sel[i][j] = -1; end
      for (int j = 0; j < 64; j++) selh[i][j] = -1;
    end
  endtask

  // Called just after a rising edge; op_done is sampled at the next edge.
  task automatic start_frame();
    clr_rec();
    op_done = 1'b1;
    e0 = edge_n + 1;
    @(posedge clk); #1;
    op_done = 1'b0;
  endtask

  // Advance to just after the rising edge that opens cycle k.
  task automatic goto_cycle(input int k);
    int n;
    n = 0;
    while (edge_n < e0 + k - 1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(input int i, input string tag);
    int n;
    n = 0;
    while (done_cnt[i] == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq(tag, int'(done_cnt[i] > 0), 1);
  endtask

  initial begin
    clr_rec();
    // Reset: outputs low before and after the first edges.
    #3;
    chk_eq("rst_outs0_async", int'(outs0), 0);
    chk_eq("rst_outs1_async", int'(outs1), 0);
    repeat (3) @(posedge clk);
    #2;
    chk_eq("rst_outs0_held", int'(outs0), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Nominal frame on both instances.
    start_frame();
    wait_done(0, "nom_done0_seen");
    wait_done(1, "nom_done1_seen");
    repeat (4) @(posedge clk); #1;
    chk_eq("nom_reg_cyc0", reg_cyc[0], 1);
    chk_eq("nom_reg_cyc1", reg_cyc[1], 1);
    chk_eq("nom_tx_cnt0", ts_cnt[0], 4);
    chk_eq("nom_tx0_0", ts_cyc[0][0], 2);
    chk_eq("nom_tx0_1", ts_cyc[0][1], 16);
    chk_eq("nom_tx0_2", ts_cyc[0][2], 30);
    chk_eq("nom_tx0_3", ts_cyc[0][3], 44);
    chk_eq("nom_sel0_0", ts_sel[0][0], 1);
    chk_eq("nom_sel0_1", ts_sel[0][1], 2);
    chk_eq("nom_sel0_2", ts_sel[0][2], 4);
    chk_eq("nom_sel0_3", ts_sel[0][3], 8);
    chk_eq("nom_done_cyc0", done_cyc[0], 56);
    chk_eq("nom_done_cnt0", done_cnt[0], 1);
    chk_eq("nom_selh0_latch", selh[0][1], 0);
    chk_eq("nom_selh0_waitdone", selh[0][10], 1);
    chk_eq("nom_selh0_gap", selh[0][14], 0);
    chk_eq("nom_selh0_byte1", selh[0][16], 2);
    chk_eq("nom_tx1_1", ts_cyc[1][1], 14);
    chk_eq("nom_tx1_3", ts_cyc[1][3], 38);
    chk_eq("nom_sel1_0", ts_sel[1][0], 8);
    chk_eq("nom_sel1_1", ts_sel[1][1], 4);
    chk_eq("nom_sel1_3", ts_sel[1][3], 1);
    chk_eq("nom_done_cyc1", done_cyc[1], 50);
    chk_eq("nom_done_cnt1", done_cnt[1], 1);

    // Timeout on u0 (no UART response); overrun on u1 during its byte-1 WAIT_DONE.
    uart_en[0] = 1'b0;
    start_frame();
    goto_cycle(20);
    op_done = 1'b1;
    @(posedge clk); #1;
    op_done = 1'b0;
    wait_done(1, "ovr_done1_seen");
    repeat (4) @(posedge clk); #1;
    chk_eq("to_eto_cyc0", eto_cyc[0], 11);
    chk_eq("to_eto0", int'(eto[0]), 1);
    chk_eq("to_busy0", int'(sbusy[0]), 0);
    chk_eq("to_tx_cnt0", ts_cnt[0], 1);
    chk_eq("to_done_cnt0", done_cnt[0], 0);
    chk_eq("err_state_no_ovr0", int'(eov[0]), 0);
    chk_eq("ovr_eov1", int'(eov[1]), 1);
    chk_eq("ovr_tx_cnt1", ts_cnt[1], 4);
    chk_eq("ovr_tx1_3", ts_cyc[1][3], 38);
    chk_eq("ovr_done_cnt1", done_cnt[1], 1);
    chk_eq("ovr_done_cyc1", done_cyc[1], 50);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk_eq("clr_eto0", int'(eto[0]), 0);
    chk_eq("clr_eov1", int'(eov[1]), 0);
    chk_eq("clr_busy0", int'(sbusy[0]), 0);
    uart_en[0] = 1'b1;
    @(posedge clk); #1;

    // Abort in u0's gap after byte 2 (u1 is in its last WAIT_DONE then).
    start_frame();
    goto_cycle(42);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_eq("abt_busy0", int'(sbusy[0]), 0);
    chk_eq("abt_busy1", int'(sbusy[1]), 0);
    repeat (20) @(posedge clk); #1;
    chk_eq("abt_tx_cnt0", ts_cnt[0], 3);
    chk_eq("abt_tx_cnt1", ts_cnt[1], 4);
    chk_eq("abt_done_cnt0", done_cnt[0], 0);
    chk_eq("abt_done_cnt1", done_cnt[1], 0);
    chk_eq("abt_flags0", int'({eto[0], eov[0]}), 0);
    start_frame();
    wait_done(0, "rst_frame_done0_seen");
    chk_eq("abt_restart_sel0", ts_sel[0][0], 1);
    chk_eq("abt_restart_tx0", ts_cyc[0][0], 2);
    chk_eq("abt_restart_sel1", ts_sel[1][0], 8);
    repeat (4) @(posedge clk); #1;

    // Async reset between edges while u0 sits in WAIT_ACK.
    uart_en[0] = 1'b0;
    start_frame();
    goto_cycle(5);
    chk_eq("mid_waitack_sel0", int'(selv[3:0]), 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk_eq("arst_outs0", int'(outs0), 0);
    chk_eq("arst_outs1", int'(outs1), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    uart_en[0] = 1'b1;
    @(posedge clk); #1;
    start_frame();
    wait_done(0, "post_rst_done0_seen");
    chk_eq("post_rst_reg0", reg_cyc[0], 1);
    chk_eq("post_rst_tx0", ts_cyc[0][0], 2);
    chk_eq("post_rst_done0", done_cyc[0], 56);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
